// File: rtl/magcmp_pkg.sv
// rtl/magcmp_pkg.sv - shared types and helpers for the sequential magnitude comparator
package magcmp_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  typedef enum logic [1:0] {CMP_LT, CMP_EQ, CMP_GT} cmp_t;

  // Digit index width; a single-digit build still needs a 1-bit counter
  function automatic int idx_width(input int ndig);
    int w;
    w = $clog2(ndig);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/magcmp_digit.sv
// rtl/magcmp_digit.sv - combinational unsigned compare of one DIGIT-bit slice
module magcmp_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             lt
);

  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/magcmp_seq.sv
// rtl/magcmp_seq.sv - multi-cycle MSB-first magnitude comparator with valid/ready handshakes
// Define MAGCMP_EARLY_EXIT_EN to leave the scan on the first differing digit.
module magcmp_seq
  import magcmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = idx_width(NDIG);
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  state_t          state, next_state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    j;
  cmp_t             res;
  logic             found;
  logic [DIGIT-1:0] dig_a, dig_b;
  logic             dig_gt, dig_lt;
  logic             scan_exit;
  logic [WIDTH-1:0] msb_mask;

  // Flipping both MSBs maps two's-complement order onto unsigned order
  assign msb_mask = {is_signed, {(WIDTH-1){1'b0}}};

  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (j == IW'(k)) begin
        dig_a = a_q[WIDTH-1-k*DIGIT -: DIGIT];
        dig_b = b_q[WIDTH-1-k*DIGIT -: DIGIT];
      end
    end
  end

  magcmp_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (dig_a),
    .b  (dig_b),
    .gt (dig_gt),
    .lt (dig_lt)
  );

`ifdef MAGCMP_EARLY_EXIT_EN
  assign scan_exit = (j == LAST) || dig_gt || dig_lt;
`else
  assign scan_exit = (j == LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    a_gt_b     = 1'b0;
    a_eq_b     = 1'b0;
    a_lt_b     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = SCAN;
      end
      SCAN: begin
        if (scan_exit) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        a_gt_b    = (res == CMP_GT);
        a_eq_b    = (res == CMP_EQ);
        a_lt_b    = (res == CMP_LT);
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      j     <= '0;
      res   <= CMP_LT;
      found <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a ^ msb_mask;
            b_q   <= b ^ msb_mask;
            j     <= '0;
            found <= 1'b0;
          end
        end
        SCAN: begin
          // Only the first differing digit is recorded
          if (!found && (dig_gt || dig_lt)) begin
            res   <= dig_gt ? CMP_GT : CMP_LT;
            found <= 1'b1;
          end else if (!found && (j == LAST)) begin
            res <= CMP_EQ;
          end
          if (!scan_exit) j <= j + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
